// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared types for the register-file write-port arbiter.
//   arb_state_e : arbiter FSM states
//   wb_req_t    : one register-file write request (destination + data)
//   grant_e     : which source owns the write port in a given cycle
// WB_XLEN must match the XLEN parameter of wb_port_arbiter.
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        MDU_FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_PIPE   = 2'd1,
        GNT_FIFO   = 2'd2,
        GNT_BYPASS = 2'd3
    } grant_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// Synchronous FIFO of wb_req_t holding MDU results until the write port is free.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_push_data write one entry (ignored when full)
//   i_pop               drop the head entry (ignored when empty)
//   o_head              entry at the read pointer
//   o_full, o_empty     status from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  wb_req_t i_push_data,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    wb_req_t      r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; entries are only visible between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the register-file write port between the single-cycle write-back
// stage (priority) and the valid/ready MDU, whose results are buffered in a
// FIFO. A wait counter forces an MDU drain by stalling the pipeline after the
// FIFO has lost arbitration MAX_WAIT times in a row.
//
// Optional feature (macro WB_ARB_BYPASS_EN): with the FIFO empty, the FSM in
// PIPE_PRI and no pipe request, an MDU result goes straight to the write port
// without passing through the FIFO.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_pipe_rf_en/rd/wdata        write-back stage request
//   o_pipe_stall                 pipeline must hold its write-back (comb.)
//   i_mdu_valid/rd/wdata         MDU result
//   o_mdu_ready                  result accepted this cycle (comb., = !full)
//   o_rf_wen/waddr/wdata         register-file write port (registered)
//   o_mdu_pending                FIFO non-empty
//
// States:
//   PIPE_PRI  | pipe wins; FIFO served when pipe idle; wait counter runs
//   MDU_FORCE | FIFO head granted, pipe stalled for one cycle
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4,
    parameter int XLEN       = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pipe_rf_en,
    input  logic [4:0]      i_pipe_rd,
    input  logic [XLEN-1:0] i_pipe_wdata,
    output logic            o_pipe_stall,
    input  logic            i_mdu_valid,
    input  logic [4:0]      i_mdu_rd,
    input  logic [XLEN-1:0] i_mdu_wdata,
    output logic            o_mdu_ready,
    output logic            o_rf_wen,
    output logic [4:0]      o_rf_waddr,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic            o_mdu_pending
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    arb_state_e    r_state;
    logic [CW-1:0] r_wait;
    logic          r_rf_wen;
    logic [4:0]    r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;

    grant_e  w_grant;
    wb_req_t w_pipe_req;
    wb_req_t w_mdu_req;
    wb_req_t w_head;
    wb_req_t w_sel;
    logic    w_full;
    logic    w_empty;
    logic    w_push;
    logic    w_pop;

    assign w_pipe_req = '{rd: i_pipe_rd, wdata: i_pipe_wdata};
    assign w_mdu_req  = '{rd: i_mdu_rd,  wdata: i_mdu_wdata};

    always_comb begin
        w_grant = GNT_NONE;
        case (r_state)
            PIPE_PRI: begin
                if (i_pipe_rf_en) begin
                    w_grant = GNT_PIPE;
                end else if (!w_empty) begin
                    w_grant = GNT_FIFO;
                end
`ifdef WB_ARB_BYPASS_EN
                else if (i_mdu_valid) begin
                    w_grant = GNT_BYPASS;
                end
`endif
            end
            MDU_FORCE: begin
                if (!w_empty) begin
                    w_grant = GNT_FIFO;
                end
            end
            default: w_grant = GNT_NONE;
        endcase
    end

    always_comb begin
        w_sel = w_pipe_req;
        case (w_grant)
            GNT_FIFO:   w_sel = w_head;
            GNT_BYPASS: w_sel = w_mdu_req;
            default:    w_sel = w_pipe_req;
        endcase
    end

    // Ready looks only at the registered full flag, so a pop cannot make room
    // for a push in the same cycle.
    assign o_mdu_ready  = !w_full;
    assign w_push       = i_mdu_valid && !w_full && (w_grant != GNT_BYPASS);
    assign w_pop        = (w_grant == GNT_FIFO);
    assign o_pipe_stall = (r_state == MDU_FORCE) && i_pipe_rf_en;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_mdu_req),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= PIPE_PRI;
            r_wait     <= '0;
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            // Writes to x0 still consume their grant but never reach the file.
            r_rf_wen <= (w_grant != GNT_NONE) && (w_sel.rd != 5'd0);
            if (w_grant != GNT_NONE) begin
                r_rf_waddr <= w_sel.rd;
                r_rf_wdata <= w_sel.wdata;
            end

            case (r_state)
                PIPE_PRI: begin
                    if (w_grant == GNT_FIFO || w_empty) begin
                        r_wait <= '0;
                    end else if (w_grant == GNT_PIPE) begin
                        if (r_wait == WAIT_LAST) begin
                            r_state <= MDU_FORCE;
                        end else begin
                            r_wait <= r_wait + WAIT_ONE;
                        end
                    end
                end
                MDU_FORCE: begin
                    r_wait  <= '0;
                    r_state <= PIPE_PRI;
                end
                default: begin
                    r_wait  <= '0;
                    r_state <= PIPE_PRI;
                end
            endcase
        end
    end

    assign o_rf_wen      = r_rf_wen;
    assign o_rf_waddr    = r_rf_waddr;
    assign o_rf_wdata    = r_rf_wdata;
    assign o_mdu_pending = !w_empty;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_rf_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mdu_pending;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4),
        .XLEN       (32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pipe_rf_en  (pipe_rf_en),
        .i_pipe_rd     (pipe_rd),
        .i_pipe_wdata  (pipe_wdata),
        .o_pipe_stall  (pipe_stall),
        .i_mdu_valid   (mdu_valid),
        .i_mdu_rd      (mdu_rd),
        .i_mdu_wdata   (mdu_wdata),
        .o_mdu_ready   (mdu_ready),
        .o_rf_wen      (rf_wen),
        .o_rf_waddr    (rf_waddr),
        .o_rf_wdata    (rf_wdata),
        .o_mdu_pending (mdu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic en, input logic [4:0] rd);
        pipe_rf_en = en;
        pipe_rd    = rd;
        pipe_wdata = 32'h1000_0000 | {27'd0, rd};
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v;
        mdu_rd    = rd;
        mdu_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_pipe(1'b0, 5'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rf_regs: waddr=%0d wdata=%h, want 0/0", rf_waddr, rf_wdata);
        end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            if (rf_wen !== 1'b0 || mdu_ready !== 1'b1 || mdu_pending !== 1'b0 || pipe_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: wen=%b ready=%b pending=%b stall=%b, want 0 1 0 0",
                         i, rf_wen, mdu_ready, mdu_pending, pipe_stall);
            end
            n_checks++;
            step();
        end
    endtask

    task automatic test_mdu_only();
        drive_mdu(1'b1, 5'd5, 32'hDEAD_BEEF);
        if (mdu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mdu_only_ready: got %b want 1", mdu_ready);
        end
        n_checks++;
        step();
        drive_mdu(1'b0, 5'd0, 32'd0);
`ifdef WB_ARB_BYPASS_EN
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF || mdu_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL mdu_only_bypass: wen=%b waddr=%0d wdata=%h pend=%b, want 1 5 deadbeef 0",
                     rf_wen, rf_waddr, rf_wdata, mdu_pending);
        end
        n_checks++;
`else
        if (rf_wen !== 1'b0 || mdu_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL mdu_only_buffered: wen=%b pend=%b, want 0 1", rf_wen, mdu_pending);
        end
        n_checks++;
        step();
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF || mdu_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL mdu_only_write: wen=%b waddr=%0d wdata=%h pend=%b, want 1 5 deadbeef 0",
                     rf_wen, rf_waddr, rf_wdata, mdu_pending);
        end
        n_checks++;
`endif
        step();
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL no_grant_hold: wen=%b waddr=%0d wdata=%h, want 0 5 deadbeef",
                     rf_wen, rf_waddr, rf_wdata);
        end
        n_checks++;
    endtask

    task automatic test_starvation();
        drive_pipe(1'b1, 5'd1);
        drive_mdu(1'b1, 5'd7, 32'hA5A5_0007);
        step();
        drive_mdu(1'b0, 5'd0, 32'd0);
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd1) begin
            n_fail++;
            $display("FAIL starve_first: wen=%b waddr=%0d, want 1 1", rf_wen, rf_waddr);
        end
        n_checks++;
        for (int k = 2; k <= 5; k++) begin
            drive_pipe(1'b1, 5'(k));
            if (pipe_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_nostall[%0d]: stall=%b want 0", k, pipe_stall);
            end
            n_checks++;
            step();
            if (rf_wen !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== (32'h1000_0000 | k)) begin
                n_fail++;
                $display("FAIL starve_pipe_win[%0d]: wen=%b waddr=%0d wdata=%h", k, rf_wen, rf_waddr, rf_wdata);
            end
            n_checks++;
        end
        drive_pipe(1'b1, 5'd6);
        if (pipe_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_force_stall: stall=%b want 1", pipe_stall);
        end
        n_checks++;
        step();
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA5A5_0007) begin
            n_fail++;
            $display("FAIL starve_force_write: wen=%b waddr=%0d wdata=%h, want 1 7 a5a50007",
                     rf_wen, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (pipe_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_release: stall=%b want 0", pipe_stall);
        end
        n_checks++;
        step();
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h1000_0006 || mdu_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_held_pipe: wen=%b waddr=%0d wdata=%h pend=%b, want 1 6 10000006 0",
                     rf_wen, rf_waddr, rf_wdata, mdu_pending);
        end
        n_checks++;
        drive_pipe(1'b0, 5'd0);
        step();
    endtask

    task automatic test_fifo_full();
        logic [4:0]  exp_addr [9];
        logic        exp_ready [7];
        logic        exp_stall [7];
        exp_addr  = '{5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd10, 5'd26, 5'd11, 5'd12};
        exp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 9; c++) begin
            case (c)
                0: begin drive_pipe(1'b1, 5'd21); drive_mdu(1'b1, 5'd10, 32'hB000_0010); end
                1: begin drive_pipe(1'b1, 5'd22); drive_mdu(1'b1, 5'd11, 32'hB000_0011); end
                2: begin drive_pipe(1'b1, 5'd23); drive_mdu(1'b1, 5'd12, 32'hB000_0012); end
                3: drive_pipe(1'b1, 5'd24);
                4: drive_pipe(1'b1, 5'd25);
                5: drive_pipe(1'b1, 5'd26);
                6: drive_pipe(1'b1, 5'd26);
                default: begin drive_pipe(1'b0, 5'd0); drive_mdu(1'b0, 5'd0, 32'd0); end
            endcase
            if (c < 7) begin
                if (mdu_ready !== exp_ready[c] || pipe_stall !== exp_stall[c]) begin
                    n_fail++;
                    $display("FAIL full_hs[%0d]: ready=%b stall=%b, want %b %b",
                             c, mdu_ready, pipe_stall, exp_ready[c], exp_stall[c]);
                end
                n_checks++;
            end
            step();
            if (rf_wen !== 1'b1 || rf_waddr !== exp_addr[c]) begin
                n_fail++;
                $display("FAIL full_order[%0d]: wen=%b waddr=%0d, want 1 %0d", c, rf_wen, rf_waddr, exp_addr[c]);
            end
            n_checks++;
        end
        if (rf_wdata !== 32'hB000_0012) begin
            n_fail++;
            $display("FAIL full_last_data: got %h want b0000012", rf_wdata);
        end
        n_checks++;
        step();
        if (rf_wen !== 1'b0 || mdu_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: wen=%b pend=%b, want 0 0", rf_wen, mdu_pending);
        end
        n_checks++;
    endtask

    task automatic test_x0();
        drive_mdu(1'b1, 5'd0, 32'h0000_1234);
        step();
        drive_mdu(1'b0, 5'd0, 32'd0);
        if (rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_mdu_a: wen=%b want 0", rf_wen);
        end
        n_checks++;
        step();
        if (rf_wen !== 1'b0 || mdu_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_mdu_b: wen=%b pend=%b, want 0 0", rf_wen, mdu_pending);
        end
        n_checks++;
        drive_pipe(1'b1, 5'd0);
        step();
        drive_pipe(1'b0, 5'd0);
        if (rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_pipe: wen=%b want 0", rf_wen);
        end
        n_checks++;
        step();
    endtask

    task automatic test_reset_mid_op();
        drive_pipe(1'b1, 5'd1);
        drive_mdu(1'b1, 5'd13, 32'hC000_0013);
        step();
        drive_pipe(1'b1, 5'd2);
        drive_mdu(1'b1, 5'd14, 32'hC000_0014);
        step();
        drive_mdu(1'b0, 5'd0, 32'd0);
        if (mdu_pending !== 1'b1 || mdu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_setup: pend=%b ready=%b, want 1 0", mdu_pending, mdu_ready);
        end
        n_checks++;
        drive_pipe(1'b0, 5'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (mdu_pending !== 1'b0 || rf_wen !== 1'b0 || rf_waddr !== 5'd0 || mdu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_state: pend=%b wen=%b waddr=%0d ready=%b, want 0 0 0 1",
                     mdu_pending, rf_wen, rf_waddr, mdu_ready);
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rf_wen !== 1'b0 || mdu_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_stale[%0d]: wen=%b pend=%b, want 0 0", i, rf_wen, mdu_pending);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_mdu_only();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
